// File: rtl/musa_ctrl_pkg.sv
// ============================================================================
// musa_ctrl_pkg
// Shared constants and types for the MUSA multicycle control unit: opcodes,
// ALU function codes, branch selects, stage encoding and the control word.
// Revision: 1.0
// ============================================================================
`default_nettype none

package musa_ctrl_pkg;

  // Field widths of the stored control word
  localparam int CW_FW  = 6;
  localparam int CW_BRW = 3;

  // Opcodes (team table)
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_NOP   = 6'b000001;
  localparam logic [5:0] OP_JPC   = 6'b000010;
  localparam logic [5:0] OP_CALL  = 6'b000011;
  localparam logic [5:0] OP_RET   = 6'b000100;
  localparam logic [5:0] OP_JR    = 6'b000101;
  localparam logic [5:0] OP_BRFL  = 6'b000110;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SUBI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_HALT  = 6'b111000;

  // ALU function codes driven for immediate and memory classes
  localparam logic [CW_FW-1:0] FN_ADD = 6'b100000;
  localparam logic [CW_FW-1:0] FN_SUB = 6'b100010;
  localparam logic [CW_FW-1:0] FN_AND = 6'b100100;
  localparam logic [CW_FW-1:0] FN_OR  = 6'b100101;

  // PC source selects
  localparam logic [CW_BRW-1:0] BR_SEQ  = 3'b000;
  localparam logic [CW_BRW-1:0] BR_JR   = 3'b001;
  localparam logic [CW_BRW-1:0] BR_CALL = 3'b010;
  localparam logic [CW_BRW-1:0] BR_HALT = 3'b011;
  localparam logic [CW_BRW-1:0] BR_JPC  = 3'b100;

  // Stage encoding, visible on the stage output
  typedef enum logic [2:0] {
    STG_IF   = 3'd0,
    STG_ID   = 3'd1,
    STG_EX   = 3'd2,
    STG_MEM  = 3'd3,
    STG_WB   = 3'd4,
    STG_HALT = 3'd5
  } stage_e;

  // Decoded control word: datapath strobes, ALU function, PC select and
  // the instruction class bits that steer the sequencer.
  typedef struct packed {
    logic              read_reg;
    logic              write_reg;
    logic              read_data;
    logic              write_data;
    logic              immediat;
    logic              control_function;
    logic              control_alu_data;
    logic              rtrn;
    logic              pop;
    logic              push;
    logic              brfl_control;
    logic              add_pc;
    logic [CW_FW-1:0]  fnction;
    logic [CW_BRW-1:0] branch;
    logic              is_alu;
    logic              is_lw;
    logic              is_sw;
    logic              is_jmp;
    logic              is_halt;
  } ctrl_word_t;

endpackage

`default_nettype wire

// File: rtl/musa_decode_rom.sv
// ============================================================================
// musa_decode_rom
// Combinational opcode decoder: maps an opcode to its control word and flags
// opcodes outside the table, which decode to the all-zero (nop) word.
// Revision: 1.0
// ============================================================================
`default_nettype none

module musa_decode_rom
  import musa_ctrl_pkg::*;
#(
  parameter int OPW = 6
) (
  input  logic [OPW-1:0] opcode_i,
  output ctrl_word_t     cw_o,
  output logic           illegal_o
);

  // Opcode lookup; anything not listed becomes a nop with the illegal flag
  always_comb begin
    cw_o      = '0;
    illegal_o = 1'b0;
    case (opcode_i)
      OPW'(OP_RTYPE): begin
        cw_o.read_reg  = 1'b1;
        cw_o.write_reg = 1'b1;
        cw_o.is_alu    = 1'b1;
      end
      OPW'(OP_ADDI), OPW'(OP_SUBI), OPW'(OP_ANDI), OPW'(OP_ORI): begin
        cw_o.read_reg         = 1'b1;
        cw_o.write_reg        = 1'b1;
        cw_o.immediat         = 1'b1;
        cw_o.control_function = 1'b1;
        cw_o.is_alu           = 1'b1;
        case (opcode_i)
          OPW'(OP_SUBI): cw_o.fnction = FN_SUB;
          OPW'(OP_ANDI): cw_o.fnction = FN_AND;
          OPW'(OP_ORI):  cw_o.fnction = FN_OR;
          default:       cw_o.fnction = FN_ADD;
        endcase
      end
      OPW'(OP_LW): begin
        cw_o.read_reg         = 1'b1;
        cw_o.write_reg        = 1'b1;
        cw_o.read_data        = 1'b1;
        cw_o.control_alu_data = 1'b1;
        cw_o.fnction          = FN_ADD;
        cw_o.is_lw            = 1'b1;
      end
      OPW'(OP_SW): begin
        cw_o.read_reg         = 1'b1;
        cw_o.write_data       = 1'b1;
        cw_o.control_alu_data = 1'b1;
        cw_o.fnction          = FN_ADD;
        cw_o.is_sw            = 1'b1;
      end
      OPW'(OP_CALL): begin
        cw_o.branch = BR_CALL;
        cw_o.push   = 1'b1;
        cw_o.is_jmp = 1'b1;
      end
      OPW'(OP_RET): begin
        // rtrn marks the return path alongside the stack pop
        cw_o.pop    = 1'b1;
        cw_o.add_pc = 1'b1;
        cw_o.rtrn   = 1'b1;
        cw_o.is_jmp = 1'b1;
      end
      OPW'(OP_JR): begin
        cw_o.branch = BR_JR;
        cw_o.is_jmp = 1'b1;
      end
      OPW'(OP_JPC): begin
        cw_o.branch   = BR_JPC;
        cw_o.immediat = 1'b1;
        cw_o.is_jmp   = 1'b1;
      end
      OPW'(OP_BRFL): begin
        cw_o.brfl_control = 1'b1;
        cw_o.is_jmp       = 1'b1;
      end
      OPW'(OP_HALT): begin
        cw_o.branch  = BR_HALT;
        cw_o.is_halt = 1'b1;
      end
      OPW'(OP_NOP): begin
        cw_o = '0;
      end
      default: begin
        illegal_o = 1'b1;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/musa_multicycle_ctrl.sv
// ============================================================================
// musa_multicycle_ctrl
// Multicycle stage sequencer for the MUSA core (IF/ID/EX/MEM/WB/HALT) with
// per-class instruction length, memory wait handshake and optional watchdog.
// All strobes derive from the registered stage and control word.
// Revision: 1.0
// ============================================================================
`default_nettype none

module musa_multicycle_ctrl
  import musa_ctrl_pkg::*;
#(
  parameter int OPW        = 6,
  parameter int FW         = 6,
  parameter int BRW        = 3,
  parameter int VAR_LEN    = 1,
  parameter int WAIT_LIMIT = 0
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [OPW-1:0] opcode,
  input  logic           mem_ready,
  input  logic           resume,
  output logic           ir_load,
  output logic           read_reg,
  output logic           write_reg,
  output logic           read_data,
  output logic           write_data,
  output logic           immediat,
  output logic           control_function,
  output logic           control_alu_data,
  output logic           rtrn,
  output logic           pop,
  output logic           push,
  output logic           brfl_control,
  output logic           add_pc,
  output logic [FW-1:0]  fnction,
  output logic [BRW-1:0] branch,
  output logic           write_pc,
  output logic [2:0]     stage,
  output logic           halted,
  output logic           illegal_op,
  output logic           mem_timeout,
  output logic           instr_retired
);

  localparam logic [2:0] S_IF   = STG_IF;
  localparam logic [2:0] S_ID   = STG_ID;
  localparam logic [2:0] S_EX   = STG_EX;
  localparam logic [2:0] S_MEM  = STG_MEM;
  localparam logic [2:0] S_WB   = STG_WB;
  localparam logic [2:0] S_HALT = STG_HALT;

  logic [2:0] stage_q, stage_d;
  ctrl_word_t cw_q, cw_d;
  logic       illegal_q, illegal_d;
  ctrl_word_t w_rom_cw;
  logic       w_rom_illegal;
  logic       w_last;
  logic       w_timeout;
  logic       w_exec;

  musa_decode_rom #(
    .OPW (OPW)
  ) u_rom (
    .opcode_i  (opcode),
    .cw_o      (w_rom_cw),
    .illegal_o (w_rom_illegal)
  );

  // Watchdog on consecutive not-ready cycles while fetching or in memory
  if (WAIT_LIMIT > 0) begin : g_wdog
    localparam int CNT_W = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT) : 1;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             w_waiting;

    assign w_waiting = ((stage_q == S_IF) || (stage_q == S_MEM)) && !mem_ready;
    assign w_timeout = w_waiting && (cnt_q == CNT_W'(WAIT_LIMIT - 1));

    // Count while waiting; any ready, stage change or expiry restarts it
    always_comb begin
      cnt_d = '0;
      if (w_waiting && !w_timeout) begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    // Wait counter register
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end
  end else begin : g_no_wdog
    assign w_timeout = 1'b0;
  end

  // Next stage and detection of the instruction's final cycle
  always_comb begin
    stage_d = stage_q;
    w_last  = 1'b0;
    case (stage_q)
      S_IF: begin
        if (mem_ready) begin
          stage_d = S_ID;
        end
      end
      S_ID: begin
        stage_d = S_EX;
      end
      S_EX: begin
        if (cw_q.is_halt) begin
          stage_d = S_HALT;
        end else if ((VAR_LEN == 0) || cw_q.is_lw || cw_q.is_sw) begin
          stage_d = S_MEM;
        end else if (cw_q.is_jmp || !cw_q.is_alu) begin
          // control transfers, nop and illegal opcodes retire here
          stage_d = S_IF;
          w_last  = 1'b1;
        end else begin
          stage_d = S_WB;
        end
      end
      S_MEM: begin
        // ready has priority over a watchdog expiry in the same cycle
        if (mem_ready) begin
          if ((VAR_LEN == 0) || cw_q.is_lw) begin
            stage_d = S_WB;
          end else begin
            stage_d = S_IF;
            w_last  = 1'b1;
          end
        end else if (w_timeout) begin
          stage_d = S_IF;
        end
      end
      S_WB: begin
        stage_d = S_IF;
        w_last  = 1'b1;
      end
      S_HALT: begin
        if (resume) begin
          stage_d = S_IF;
          w_last  = 1'b1;
        end
      end
      default: begin
        stage_d = S_IF;
      end
    endcase
  end

  // Control word captured leaving ID, dropped whenever the FSM returns to IF
  always_comb begin
    cw_d      = cw_q;
    illegal_d = illegal_q;
    if (stage_q == S_ID) begin
      cw_d      = w_rom_cw;
      illegal_d = w_rom_illegal;
    end else if (stage_d == S_IF) begin
      cw_d      = '0;
      illegal_d = 1'b0;
    end
  end

  // State and control word registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_q   <= S_IF;
      cw_q      <= '0;
      illegal_q <= 1'b0;
    end else begin
      stage_q   <= stage_d;
      cw_q      <= cw_d;
      illegal_q <= illegal_d;
    end
  end

  // Output gating: held strobes live in EX..WB, the rest in their own stage.
  // ir_load and mem_timeout are masked by rst_n so reset forces all zeros.
  assign w_exec           = (stage_q == S_EX) || (stage_q == S_MEM) || (stage_q == S_WB);
  assign ir_load          = rst_n && (stage_q == S_IF);
  assign read_reg         = w_exec && cw_q.read_reg;
  assign write_reg        = (stage_q == S_WB) && cw_q.write_reg;
  assign read_data        = (stage_q == S_MEM) && cw_q.read_data;
  assign write_data       = (stage_q == S_MEM) && cw_q.write_data;
  assign immediat         = w_exec && cw_q.immediat;
  assign control_function = w_exec && cw_q.control_function;
  assign control_alu_data = w_exec && cw_q.control_alu_data;
  assign rtrn             = w_exec && cw_q.rtrn;
  assign pop              = (stage_q == S_EX) && cw_q.pop;
  assign push             = (stage_q == S_EX) && cw_q.push;
  assign brfl_control     = w_exec && cw_q.brfl_control;
  assign add_pc           = w_exec && cw_q.add_pc;
  assign fnction          = w_exec ? FW'(cw_q.fnction) : '0;
  assign branch           = w_exec ? BRW'(cw_q.branch) : '0;
  assign write_pc         = w_last;
  assign instr_retired    = w_last;
  assign stage            = stage_q;
  assign halted           = (stage_q == S_HALT);
  assign illegal_op       = (stage_q == S_EX) && illegal_q;
  assign mem_timeout      = rst_n && w_timeout;

endmodule

`default_nettype wire

// File: tb/tb_musa_multicycle_ctrl.sv
// ============================================================================
// tb_musa_multicycle_ctrl
// Scoreboard bench: the driver issues one cycle of inputs and queues the
// expected outputs for that cycle; a monitor on the falling edge compares.
// Instance 0: VAR_LEN=1, WAIT_LIMIT=4. Instance 1: VAR_LEN=0, no watchdog.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_musa_multicycle_ctrl;
  import musa_ctrl_pkg::*;

  localparam logic [11:0] NONE = 12'h000;
  localparam logic [11:0] RR   = 12'h800;
  localparam logic [11:0] WR   = 12'h400;
  localparam logic [11:0] RD   = 12'h200;
  localparam logic [11:0] WD   = 12'h100;
  localparam logic [11:0] IMM  = 12'h080;
  localparam logic [11:0] CF   = 12'h040;
  localparam logic [11:0] CAD  = 12'h020;
  localparam logic [11:0] RTN  = 12'h010;
  localparam logic [11:0] POP  = 12'h008;
  localparam logic [11:0] PSH  = 12'h004;
  localparam logic [11:0] BRF  = 12'h002;
  localparam logic [11:0] APC  = 12'h001;

  localparam logic [4:0] ST0 = 5'b00000;
  localparam logic [4:0] WPC = 5'b10000;
  localparam logic [4:0] HLT = 5'b01000;
  localparam logic [4:0] ILL = 5'b00100;
  localparam logic [4:0] TMO = 5'b00010;
  localparam logic [4:0] RET = 5'b00001;

  localparam logic [5:0] F0 = 6'b000000;
  localparam logic [2:0] B0 = 3'b000;

  localparam logic [5:0]  ALU_OP [5] = '{OP_ADDI, OP_SUBI, OP_ANDI, OP_ORI, OP_RTYPE};
  localparam logic [5:0]  ALU_FN [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b000000};
  localparam logic [5:0]  JMP_OP [6] = '{OP_CALL, OP_RET, OP_JR, OP_JPC, OP_BRFL, OP_NOP};
  localparam logic [11:0] JMP_SB [6] = '{PSH, POP | APC | RTN, NONE, IMM, BRF, NONE};
  localparam logic [2:0]  JMP_BR [6] = '{3'b010, 3'b000, 3'b001, 3'b100, 3'b000, 3'b000};

  logic       clk;
  logic       rst_n;
  logic [5:0] op [2];
  logic [1:0] mr;
  logic [1:0] rs;

  logic [1:0] s_ir, s_rr, s_wr, s_rd, s_wd, s_imm, s_cf, s_cad, s_rtn, s_pop, s_psh, s_brf, s_apc;
  logic [1:0] s_wpc, s_hlt, s_ill, s_tmo, s_ret;
  logic [5:0] s_fn [2];
  logic [2:0] s_br [2];
  logic [2:0] s_stage [2];
  logic [29:0] obs [2];

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    musa_multicycle_ctrl #(
      .OPW        (6),
      .FW         (6),
      .BRW        (3),
      .VAR_LEN    ((gi == 0) ? 1 : 0),
      .WAIT_LIMIT ((gi == 0) ? 4 : 0)
    ) u_dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .opcode           (op[gi]),
      .mem_ready        (mr[gi]),
      .resume           (rs[gi]),
      .ir_load          (s_ir[gi]),
      .read_reg         (s_rr[gi]),
      .write_reg        (s_wr[gi]),
      .read_data        (s_rd[gi]),
      .write_data       (s_wd[gi]),
      .immediat         (s_imm[gi]),
      .control_function (s_cf[gi]),
      .control_alu_data (s_cad[gi]),
      .rtrn             (s_rtn[gi]),
      .pop              (s_pop[gi]),
      .push             (s_psh[gi]),
      .brfl_control     (s_brf[gi]),
      .add_pc           (s_apc[gi]),
      .fnction          (s_fn[gi]),
      .branch           (s_br[gi]),
      .write_pc         (s_wpc[gi]),
      .stage            (s_stage[gi]),
      .halted           (s_hlt[gi]),
      .illegal_op       (s_ill[gi]),
      .mem_timeout      (s_tmo[gi]),
      .instr_retired    (s_ret[gi])
    );

    assign obs[gi] = {s_stage[gi], s_ir[gi],
                      s_rr[gi], s_wr[gi], s_rd[gi], s_wd[gi], s_imm[gi], s_cf[gi],
                      s_cad[gi], s_rtn[gi], s_pop[gi], s_psh[gi], s_brf[gi], s_apc[gi],
                      s_fn[gi], s_br[gi],
                      s_wpc[gi], s_hlt[gi], s_ill[gi], s_tmo[gi], s_ret[gi]};
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard
  logic [29:0] q_exp [$];
  logic        q_dut [$];
  string       q_name [$];
  int          n_chk  = 0;
  int          n_pass = 0;

  logic [29:0] m_exp;
  logic [29:0] m_act;
  logic        m_d;
  string       m_nm;

  always @(negedge clk) begin
    if (q_exp.size() != 0) begin
      m_exp = q_exp.pop_front();
      m_d   = q_dut.pop_front();
      m_nm  = q_name.pop_front();
      m_act = obs[m_d];
      n_chk++;
      if (m_act === m_exp) begin
        n_pass++;
      end else begin
        $display("FAIL %s (dut%0d): got stage=%0d vec=%h, expected stage=%0d vec=%h",
                 m_nm, m_d, m_act[29:27], m_act, m_exp[29:27], m_exp);
      end
    end
  end

  // One clock cycle: release reset, drive inputs of instance d, queue expectation
  task automatic cyc(input logic d, input logic m, input logic r,
                     input logic [2:0] stg, input logic ir, input logic [11:0] sb,
                     input logic [5:0] fn, input logic [2:0] br, input logic [4:0] st,
                     input string nm);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    mr    = 2'b00;
    rs    = 2'b00;
    mr[d] = m;
    rs[d] = r;
    q_exp.push_back({stg, ir, sb, fn, br, st});
    q_dut.push_back(d);
    q_name.push_back(nm);
  endtask

  // One cycle with reset held: everything must read zero
  task automatic rcheck(input logic d, input string nm);
    @(posedge clk);
    #1;
    mr = 2'b00;
    rs = 2'b00;
    q_exp.push_back(30'd0);
    q_dut.push_back(d);
    q_name.push_back(nm);
  endtask

  initial begin
    rst_n = 1'b0;
    mr    = 2'b00;
    rs    = 2'b00;
    op[0] = OP_NOP;
    op[1] = OP_NOP;

    rcheck(1'b0, "reset_d0");
    rcheck(1'b1, "reset_d1");

    // ALU immediates and R-type: IF, ID, EX, WB
    for (int i = 0; i < 5; i++) begin
      logic [11:0] sb;
      sb = (i < 4) ? (RR | IMM | CF) : RR;
      op[0] = ALU_OP[i];
      cyc(1'b0, 1'b1, 1'b0, 3'd0, 1'b1, NONE, F0, B0, ST0, $sformatf("alu%0d_if", i));
      cyc(1'b0, 1'b1, 1'b0, 3'd1, 1'b0, NONE, F0, B0, ST0, $sformatf("alu%0d_id", i));
      cyc(1'b0, 1'b1, 1'b0, 3'd2, 1'b0, sb, ALU_FN[i], B0, ST0, $sformatf("alu%0d_ex", i));
      cyc(1'b0, 1'b1, 1'b0, 3'd4, 1'b0, sb | WR, ALU_FN[i], B0, WPC | RET, $sformatf("alu%0d_wb", i));
    end

    // lw with three wait cycles in MEM: 8 cycles total
    op[0] = OP_LW;
    cyc(1'b0, 1'b1, 1'b0, 3'd0, 1'b1, NONE, F0, B0, ST0, "lw_if");
    cyc(1'b0, 1'b1, 1'b0, 3'd1, 1'b0, NONE, F0, B0, ST0, "lw_id");
    cyc(1'b0, 1'b1, 1'b0, 3'd2, 1'b0, RR | CAD, 6'b100000, B0, ST0, "lw_ex");
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b0, 1'b0, 3'd3, 1'b0, RR | RD | CAD, 6'b100000, B0, ST0, $sformatf("lw_memwait%0d", i));
    end
    cyc(1'b0, 1'b1, 1'b0, 3'd3, 1'b0, RR | RD | CAD, 6'b100000, B0, ST0, "lw_memrdy");
    cyc(1'b0, 1'b1, 1'b0, 3'd4, 1'b0, RR | WR | CAD, 6'b100000, B0, WPC | RET, "lw_wb");

    // Short class: IF, ID, EX with retirement in EX
    for (int i = 0; i < 6; i++) begin
      op[0] = JMP_OP[i];
      cyc(1'b0, 1'b1, 1'b0, 3'd0, 1'b1, NONE, F0, B0, ST0, $sformatf("jmp%0d_if", i));
      cyc(1'b0, 1'b1, 1'b0, 3'd1, 1'b0, NONE, F0, B0, ST0, $sformatf("jmp%0d_id", i));
      cyc(1'b0, 1'b1, 1'b0, 3'd2, 1'b0, JMP_SB[i], F0, JMP_BR[i], WPC | RET, $sformatf("jmp%0d_ex", i));
    end

    // halt, five HALT cycles, resume on the fifth
    op[0] = OP_HALT;
    cyc(1'b0, 1'b1, 1'b0, 3'd0, 1'b1, NONE, F0, B0, ST0, "halt_if");
    cyc(1'b0, 1'b1, 1'b0, 3'd1, 1'b0, NONE, F0, B0, ST0, "halt_id");
    cyc(1'b0, 1'b1, 1'b0, 3'd2, 1'b0, NONE, F0, 3'b011, ST0, "halt_ex");
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 1'b1, 1'b0, 3'd5, 1'b0, NONE, F0, B0, HLT, $sformatf("halt_wait%0d", i));
    end
    cyc(1'b0, 1'b1, 1'b1, 3'd5, 1'b0, NONE, F0, B0, HLT | WPC | RET, "halt_resume");

    // resume outside HALT has no effect
    op[0] = OP_JR;
    cyc(1'b0, 1'b1, 1'b1, 3'd0, 1'b1, NONE, F0, B0, ST0, "post_halt_if");
    cyc(1'b0, 1'b1, 1'b1, 3'd1, 1'b0, NONE, F0, B0, ST0, "resume_ign_id");
    cyc(1'b0, 1'b1, 1'b0, 3'd2, 1'b0, NONE, F0, 3'b001, WPC | RET, "resume_ign_ex");

    // sw completing immediately
    op[0] = OP_SW;
    cyc(1'b0, 1'b1, 1'b0, 3'd0, 1'b1, NONE, F0, B0, ST0, "sw_if");
    cyc(1'b0, 1'b1, 1'b0, 3'd1, 1'b0, NONE, F0, B0, ST0, "sw_id");
    cyc(1'b0, 1'b1, 1'b0, 3'd2, 1'b0, RR | CAD, 6'b100000, B0, ST0, "sw_ex");
    cyc(1'b0, 1'b1, 1'b0, 3'd3, 1'b0, RR | WD | CAD, 6'b100000, B0, WPC | RET, "sw_mem");

    // sw with memory stuck: timeout on the 4th wait cycle, back to IF
    cyc(1'b0, 1'b1, 1'b0, 3'd0, 1'b1, NONE, F0, B0, ST0, "swto_if");
    cyc(1'b0, 1'b1, 1'b0, 3'd1, 1'b0, NONE, F0, B0, ST0, "swto_id");
    cyc(1'b0, 1'b0, 1'b0, 3'd2, 1'b0, RR | CAD, 6'b100000, B0, ST0, "swto_ex");
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b0, 1'b0, 3'd3, 1'b0, RR | WD | CAD, 6'b100000, B0, ST0, $sformatf("swto_wait%0d", i));
    end
    cyc(1'b0, 1'b0, 1'b0, 3'd3, 1'b0, RR | WD | CAD, 6'b100000, B0, TMO, "swto_expire");

    // illegal opcode behaves as nop and flags in EX
    op[0] = 6'b111111;
    cyc(1'b0, 1'b1, 1'b0, 3'd0, 1'b1, NONE, F0, B0, ST0, "ill_if");
    cyc(1'b0, 1'b1, 1'b0, 3'd1, 1'b0, NONE, F0, B0, ST0, "ill_id");
    cyc(1'b0, 1'b1, 1'b0, 3'd2, 1'b0, NONE, F0, B0, ILL | WPC | RET, "ill_ex");

    // asynchronous reset in the middle of a sw MEM wait
    op[0] = OP_SW;
    cyc(1'b0, 1'b1, 1'b0, 3'd0, 1'b1, NONE, F0, B0, ST0, "arst_if");
    cyc(1'b0, 1'b1, 1'b0, 3'd1, 1'b0, NONE, F0, B0, ST0, "arst_id");
    cyc(1'b0, 1'b0, 1'b0, 3'd2, 1'b0, RR | CAD, 6'b100000, B0, ST0, "arst_ex");
    cyc(1'b0, 1'b0, 1'b0, 3'd3, 1'b0, RR | WD | CAD, 6'b100000, B0, ST0, "arst_mem");
    @(posedge clk);
    #1;
    mr = 2'b00;
    q_exp.push_back(30'd0);
    q_dut.push_back(1'b0);
    q_name.push_back("arst_async");
    #1 rst_n = 1'b0;
    rcheck(1'b0, "arst_held");
    op[0] = OP_ADDI;
    cyc(1'b0, 1'b1, 1'b0, 3'd0, 1'b1, NONE, F0, B0, ST0, "arst_restart_if");
    cyc(1'b0, 1'b1, 1'b0, 3'd1, 1'b0, NONE, F0, B0, ST0, "arst_restart_id");
    cyc(1'b0, 1'b1, 1'b0, 3'd2, 1'b0, RR | IMM | CF, 6'b100000, B0, ST0, "arst_restart_ex");

    // legacy timing: jr and call take all five stages
    op[1] = OP_JR;
    cyc(1'b1, 1'b1, 1'b0, 3'd0, 1'b1, NONE, F0, B0, ST0, "leg_jr_if");
    cyc(1'b1, 1'b1, 1'b0, 3'd1, 1'b0, NONE, F0, B0, ST0, "leg_jr_id");
    cyc(1'b1, 1'b1, 1'b0, 3'd2, 1'b0, NONE, F0, 3'b001, ST0, "leg_jr_ex");
    cyc(1'b1, 1'b1, 1'b0, 3'd3, 1'b0, NONE, F0, 3'b001, ST0, "leg_jr_mem");
    cyc(1'b1, 1'b1, 1'b0, 3'd4, 1'b0, NONE, F0, 3'b001, WPC | RET, "leg_jr_wb");
    op[1] = OP_CALL;
    cyc(1'b1, 1'b1, 1'b0, 3'd0, 1'b1, NONE, F0, B0, ST0, "leg_call_if");
    cyc(1'b1, 1'b1, 1'b0, 3'd1, 1'b0, NONE, F0, B0, ST0, "leg_call_id");
    cyc(1'b1, 1'b1, 1'b0, 3'd2, 1'b0, PSH, F0, 3'b010, ST0, "leg_call_ex");
    cyc(1'b1, 1'b1, 1'b0, 3'd3, 1'b0, NONE, F0, 3'b010, ST0, "leg_call_mem");
    cyc(1'b1, 1'b1, 1'b0, 3'd4, 1'b0, NONE, F0, 3'b010, WPC | RET, "leg_call_wb");
    cyc(1'b1, 1'b0, 1'b0, 3'd0, 1'b1, NONE, F0, B0, ST0, "leg_back_if");

    @(posedge clk);
    @(negedge clk);
    #1;
    n_chk++;
    if (q_exp.size() == 0) begin
      n_pass++;
    end else begin
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", q_exp.size());
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
